// File: rtl/rs_issue_scheduler.sv
// Issue scheduler: picks up to N ready RS entries per cycle with a rotating-priority scan,
// gating multiplies on a non-pipelined multiplier and dropping entries squashed by a mispredict.
module rs_issue_scheduler #(
   parameter int RS_SZ        = 16,
   parameter int N            = 3,
   parameter int B_MASK_WIDTH = 4,
   parameter int MULT_LAT     = 4
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic [RS_SZ-1:0]                        rs_valid,
   input  logic [RS_SZ-1:0]                        rs_ready,
   input  logic [RS_SZ-1:0]                        rs_is_mult,
   input  logic [RS_SZ-1:0][B_MASK_WIDTH-1:0]      rs_b_mask,
   input  logic                                    b_mm_mispred,
   input  logic [B_MASK_WIDTH-1:0]                 b_mm_resolve,
   input  logic                                    issue_stall,
   output logic [RS_SZ-1:0]                        rs_data_issuing,
   output logic [$clog2(N+1)-1:0]                  num_issuing,
   output logic [N-1:0][$clog2(RS_SZ)-1:0]         issue_idx,
   output logic [N-1:0]                            issue_valid,
   output logic                                    mult_busy
);

   localparam int IW = $clog2(RS_SZ);
   localparam int CW = $clog2(N+1);
   localparam int MW = $clog2(MULT_LAT+1);

   logic [IW-1:0]    ptr;
   logic [MW-1:0]    mult_cnt;
   logic [RS_SZ-1:0] base_elig;
   logic [RS_SZ-1:0] grant_vec;
   logic [CW-1:0]    grant_cnt;
   logic [IW-1:0]    last_idx;
   logic [IW-1:0]    scan_idx;
   logic             mult_take;

   // Eligibility before multiplier gating, which depends on scan order.
   always_comb begin
      base_elig = '0;
      for (int i = 0; i < RS_SZ; i++) begin
         base_elig[i] = rs_valid[i] & rs_ready[i]
                      & ~(b_mm_mispred & (|(rs_b_mask[i] & b_mm_resolve)));
      end
   end

   // Walk the RS from ptr, granting the first N eligible entries into successive slots.
   // A granted multiply blocks any further multiply for the rest of the scan.
   always_comb begin
      grant_vec   = '0;
      grant_cnt   = '0;
      last_idx    = '0;
      scan_idx    = '0;
      mult_take   = 1'b0;
      issue_idx   = '0;
      issue_valid = '0;
      for (int k = 0; k < RS_SZ; k++) begin
         scan_idx = ptr + IW'(k);
         if (reset && !issue_stall && base_elig[scan_idx] && (grant_cnt != CW'(N))
             && !(rs_is_mult[scan_idx] && ((mult_cnt != '0) || mult_take))) begin
            for (int s = 0; s < N; s++) begin
               if (grant_cnt == CW'(s)) begin
                  issue_idx[s]   = scan_idx;
                  issue_valid[s] = 1'b1;
               end
            end
            grant_vec[scan_idx] = 1'b1;
            grant_cnt           = grant_cnt + CW'(1);
            last_idx            = scan_idx;
            if (rs_is_mult[scan_idx]) begin
               mult_take = 1'b1;
            end
         end
      end
   end

   assign rs_data_issuing = grant_vec;
   assign num_issuing     = grant_cnt;
   assign mult_busy       = reset & (mult_cnt != '0);

   // Pointer moves past the last grant; the multiplier counter keeps draining through stalls.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr      <= '0;
         mult_cnt <= '0;
      end else begin
         if (grant_cnt != '0) begin
            ptr <= last_idx + IW'(1);
         end
         if (mult_take) begin
            mult_cnt <= MW'(MULT_LAT);
         end else if (mult_cnt != '0) begin
            mult_cnt <= mult_cnt - MW'(1);
         end
      end
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed, table-driven bench for rs_issue_scheduler with hand-computed expectations,
// plus a hand-written sequence for the asynchronous reset during a multiplier busy window.
module tb_rs_issue_scheduler;

   logic              clock;
   logic              reset;
   logic [15:0]       rs_valid;
   logic [15:0]       rs_ready;
   logic [15:0]       rs_is_mult;
   logic [15:0][3:0]  rs_b_mask;
   logic              b_mm_mispred;
   logic [3:0]        b_mm_resolve;
   logic              issue_stall;
   logic [15:0]       rs_data_issuing;
   logic [1:0]        num_issuing;
   logic [2:0][3:0]   issue_idx;
   logic [2:0]        issue_valid;
   logic              mult_busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0]      vr;
      logic [15:0]      mult;
      logic [15:0][3:0] mask;
      logic             mispred;
      logic [3:0]       resolve;
      logic             stall;
      logic [15:0]      exp_grant;
      logic [1:0]       exp_num;
      logic [11:0]      exp_idx;
      logic [2:0]       exp_ivalid;
      logic             exp_busy;
   } vec_t;

   vec_t vecs[$];

   rs_issue_scheduler #(
      .RS_SZ(16), .N(3), .B_MASK_WIDTH(4), .MULT_LAT(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .rs_valid(rs_valid),
      .rs_ready(rs_ready),
      .rs_is_mult(rs_is_mult),
      .rs_b_mask(rs_b_mask),
      .b_mm_mispred(b_mm_mispred),
      .b_mm_resolve(b_mm_resolve),
      .issue_stall(issue_stall),
      .rs_data_issuing(rs_data_issuing),
      .num_issuing(num_issuing),
      .issue_idx(issue_idx),
      .issue_valid(issue_valid),
      .mult_busy(mult_busy)
   );

   // 10-unit clock period; inputs change on the falling edge.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its expected value and tally the result.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drive one vector's inputs onto the DUT.
   task automatic applyStimulus(input vec_t v);
      rs_valid     = v.vr;
      rs_ready     = v.vr;
      rs_is_mult   = v.mult;
      rs_b_mask    = v.mask;
      b_mm_mispred = v.mispred;
      b_mm_resolve = v.resolve;
      issue_stall  = v.stall;
   endtask

   function automatic void addVec(input logic [15:0] vr, input logic [15:0] mult,
                                  input logic [63:0] mask, input logic mispred,
                                  input logic [3:0] resolve, input logic stall,
                                  input logic [15:0] eg, input logic [1:0] en,
                                  input logic [11:0] ei, input logic [2:0] eiv, input logic eb);
      vec_t v;
      v.vr = vr; v.mult = mult; v.mask = mask; v.mispred = mispred;
      v.resolve = resolve; v.stall = stall; v.exp_grant = eg; v.exp_num = en;
      v.exp_idx = ei; v.exp_ivalid = eiv; v.exp_busy = eb;
      vecs.push_back(v);
   endfunction

   task automatic checkAll(input string tag, input logic [15:0] eg, input logic [1:0] en,
                           input logic [11:0] ei, input logic [2:0] eiv, input logic eb);
      checkOutput({tag, ".grant"}, 32'(rs_data_issuing), 32'(eg));
      checkOutput({tag, ".num"},   32'(num_issuing),     32'(en));
      checkOutput({tag, ".idx"},   32'(issue_idx),       32'(ei));
      checkOutput({tag, ".ivalid"},32'(issue_valid),     32'(eiv));
      checkOutput({tag, ".busy"},  32'(mult_busy),       32'(eb));
   endtask

   initial begin
      // Expected values assume ptr and mult_cnt evolve from 0 across consecutive cycles.
      addVec(16'h00F0, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0070, 2'd3, 12'h654, 3'b111, 1'b0);
      addVec(16'h0080, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0080, 2'd1, 12'h007, 3'b001, 1'b0);
      addVec(16'h2000, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b0, 16'h2000, 2'd1, 12'h00D, 3'b001, 1'b0);
      addVec(16'hC003, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b0, 16'hC001, 2'd3, 12'h0FE, 3'b111, 1'b0);
      addVec(16'h0000, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0000, 2'd0, 12'h000, 3'b000, 1'b0);
      addVec(16'h001E, 16'h0006, 64'h0, 1'b0, 4'h0, 1'b0, 16'h001A, 2'd3, 12'h431, 3'b111, 1'b0);
      for (int i = 0; i < 4; i++)
         addVec(16'h0000, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0000, 2'd0, 12'h000, 3'b000, 1'b1);
      addVec(16'h001C, 16'h001C, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0004, 2'd1, 12'h002, 3'b001, 1'b0);
      for (int i = 0; i < 4; i++)
         addVec(16'h0018, 16'h0018, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0000, 2'd0, 12'h000, 3'b000, 1'b1);
      addVec(16'h0018, 16'h0018, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0008, 2'd1, 12'h003, 3'b001, 1'b0);
      addVec(16'h000F, 16'h0000, 64'h0121, 1'b1, 4'h1, 1'b0, 16'h000A, 2'd2, 12'h031, 3'b011, 1'b1);
      addVec(16'h000F, 16'h0000, 64'h0121, 1'b0, 4'h1, 1'b0, 16'h0007, 2'd3, 12'h210, 3'b111, 1'b1);
      addVec(16'h00F0, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b1, 16'h0000, 2'd0, 12'h000, 3'b000, 1'b1);
      addVec(16'h00F0, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0070, 2'd3, 12'h654, 3'b111, 1'b1);
      addVec(16'h0000, 16'h0000, 64'h0, 1'b0, 4'h0, 1'b0, 16'h0000, 2'd0, 12'h000, 3'b000, 1'b0);

      // Reset held low with ready entries present: every output must stay 0.
      reset        = 1'b0;
      rs_valid     = 16'hFFFF;
      rs_ready     = 16'hFFFF;
      rs_is_mult   = 16'h0001;
      rs_b_mask    = '0;
      b_mm_mispred = 1'b0;
      b_mm_resolve = 4'h0;
      issue_stall  = 1'b0;
      repeat (2) begin
         @(negedge clock);
         #2;
         checkAll("reset", 16'h0000, 2'd0, 12'h000, 3'b000, 1'b0);
      end
      @(negedge clock);
      reset    = 1'b1;
      rs_valid = '0;
      rs_ready = '0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         applyStimulus(vecs[i]);
         #2;
         checkAll($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_num,
                  vecs[i].exp_idx, vecs[i].exp_ivalid, vecs[i].exp_busy);
      end

      // ptr is 7 here; a lone multiply on entry 0 starts a busy window.
      @(negedge clock);
      rs_valid   = 16'h0001;
      rs_ready   = 16'h0001;
      rs_is_mult = 16'h0001;
      rs_b_mask  = '0;
      b_mm_mispred = 1'b0;
      b_mm_resolve = 4'h0;
      issue_stall  = 1'b0;
      #2;
      checkAll("mul_start", 16'h0001, 2'd1, 12'h000, 3'b001, 1'b0);
      @(negedge clock);
      rs_valid = 16'h0000;
      rs_ready = 16'h0000;
      #2;
      checkOutput("mul_busy4", 32'(mult_busy), 32'd1);
      @(negedge clock);
      rs_valid = 16'h0001;
      rs_ready = 16'h0001;
      #1;
      checkAll("mul_busy3", 16'h0000, 2'd0, 12'h000, 3'b000, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      checkAll("async_rst", 16'h0000, 2'd0, 12'h000, 3'b000, 1'b0);
      reset = 1'b1;
      #1;
      checkAll("after_rst", 16'h0001, 2'd1, 12'h000, 3'b001, 1'b0);
      @(negedge clock);
      #2;
      checkOutput("after_rst_busy", 32'(mult_busy), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Issue scheduler between the reservation station and the functional-unit issue registers. Each cycle it selects up to N valid, operand-ready RS entries with a rotating-priority scan. It gates multiply entries on a non-pipelined multiplier busy counter and drops entries squashed by a same-cycle branch mispredict. Its grant vector drives the RS `rs_data_issuing` input, and its count drives `num_issuing` toward Dispatch.

## Interface
- `RS_SZ`, default 16: RS entry count; must be a power of two.
- `N`, default 3: superscalar width, i.e. the maximum grants per cycle.
- `B_MASK_WIDTH`, default 4: branch mask width.
- `MULT_LAT`, default 4: cycles the multiplier stays busy after accepting an op; must be at least 1.
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `rs_valid`, input, RS_SZ: entry occupied.
- `rs_ready`, input, RS_SZ: both source operands ready.
- `rs_is_mult`, input, RS_SZ: entry needs the multiplier.
- `rs_b_mask`, input, RS_SZ x B_MASK_WIDTH: per-entry branch dependency mask.
- `b_mm_mispred`, input, 1: the resolving branch mispredicted this cycle.
- `b_mm_resolve`, input, B_MASK_WIDTH: one-hot bit of the resolving branch; zero means no resolution.
- `issue_stall`, input, 1: the issue register cannot accept this cycle.
- `rs_data_issuing`, output, RS_SZ: grant vector with at most N bits set.
- `num_issuing`, output, $clog2(N+1): popcount of `rs_data_issuing`.
- `issue_idx`, output, N x $clog2(RS_SZ): granted entry indices in slot order.
- `issue_valid`, output, N: slot i holds a grant; slots fill from 0 upward.
- `mult_busy`, output, 1: multiplier counter is non-zero.

## Operation
- **Eligible entry:** `rs_valid[i] & rs_ready[i] & ~squash[i] & ~(rs_is_mult[i] & mult_blocked)`.
- **Squash:** `squash[i] = b_mm_mispred & |(rs_b_mask[i] & b_mm_resolve)`.
- **Multiplier gating:** `mult_blocked` = `mult_cnt != 0`, or a multiply has already been granted in this same cycle. At most one multiply is granted per cycle.
- **Scan order:** indices `ptr, ptr+1, ..., ptr+RS_SZ-1`, mod RS_SZ.
  - The first N eligible entries are granted.
  - They occupy `issue_idx[0..]` in scan order.
- **Stall:** when `issue_stall` = 1, all grants are 0, `num_issuing` = 0 and `ptr` holds.
- **Pointer update:** with one or more grants, `ptr_next` = (index of the last granted entry + 1) mod RS_SZ. With no grants, `ptr` holds.
- **Multiplier counter:**
  - A multiply granted while the counter is 0 loads `mult_cnt` = MULT_LAT.
  - Otherwise, a non-zero counter decrements by 1 every cycle, including during stalls.
- **Resolve without mispredict:** has no effect on eligibility; RS clears its own mask bits.
- **Unused slots:** `issue_idx` for an unused slot drives 0 and `issue_valid` = 0.
- **Contract:** the scheduler never grants an entry that is not eligible in the same cycle.

## Timing
- **Outputs are combinational** from current inputs plus registered `ptr` and `mult_cnt`: zero-cycle grant latency. The RS removes granted entries at the next rising edge.
- **Registered state:** `ptr` (log2 RS_SZ bits) and `mult_cnt` ($clog2(MULT_LAT+1) bits).
- **While `reset` is low:** `ptr` = 0, `mult_cnt` = 0, and all outputs are forced to 0 (`rs_data_issuing`, `num_issuing`, `issue_idx`, `issue_valid`, `mult_busy`).
- **Reset asserted mid-operation:** clears the state immediately, independent of `clock`. This includes a multiplier busy window: the multiplier is free on the first cycle after `reset` rises.
- **Multiplier spacing:** a multiply granted in cycle T keeps `mult_busy` = 1 for cycles T+1 .. T+MULT_LAT. The next multiply can be granted in cycle T+MULT_LAT+1.
- **Wrap-around:** `ptr` = RS_SZ-1 scans index RS_SZ-1 first, then 0, 1, and so on.
- **Empty RS:** no grants; `ptr` and `mult_cnt` behave as specified above.
- **Mispredict and grants in the same cycle:** squashed entries are skipped. Surviving eligible entries are still granted, and the pointer advances past them.

## Test plan
- **Reset and basic grant:** hold `reset` low 2 cycles; check every output is 0. Release with `rs_valid` = `rs_ready` = 16'h00F0, no multiplies, `ptr` = 0. Expect grants on 4, 5, 6; `num_issuing` = 3; `issue_idx` = {4, 5, 6}; `ptr` = 7 next cycle. Following cycle with the RS updated: entry 7 granted, `ptr` = 8.
- **Wrap-around:** drive `ptr` to 14. Set valid/ready = 16'hC003. Expect grants on 14, 15, 0; `ptr` = 1 next.
- **Multiplier gating:** entries 2, 3, 4 ready, all multiplies, MULT_LAT = 4, in cycle T. Expect only entry 2 granted. `mult_busy` = 1 for T+1..T+4 with no multiply grants. Entry 3 granted at T+5.
- **Mixed ops:** ready set {1 mul, 2 mul, 3 alu, 4 alu}, multiplier free. Expect grants {1, 3, 4}.
- **Squash:** ready entries 0–3 with `rs_b_mask` {0001, 0010, 0001, 0000}. Drive `b_mm_mispred` = 1, `b_mm_resolve` = 0001. Expect grants {1, 3}. Repeat with `b_mm_mispred` = 0: expect grants {0, 1, 2}.
- **Stall and async reset:** with `issue_stall` = 1 and ready entries present, expect zero grants and `ptr` unchanged while `mult_cnt` still decrements. Pulse `reset` low between clock edges with `mult_cnt` = 3: `mult_busy` drops to 0 immediately, and a multiply is granted on the first cycle after release.
